uart_rx: RTL and testbench

- 8N1 UART receiver, the receive-side counterpart of uart_tx, on the same 50 MHz system clock.
- Synchronises the asynchronous serial line, finds the start bit, and samples each bit at its midpoint.
- Presents each received byte with a one-cycle valid strobe and flags framing errors.
- Sits between the board RX pin and the byte-consuming logic (command parser or FIFO).

---
 rtl/uart_rx.sv | 154 +++++++++++++++
 tb/tb_uart_rx.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling, framing check.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
module uart_rx #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_busy,
  output logic       frame_err,
  output logic       parity_err
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CW           = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] HALF_END = CW'(HALF_BIT - 1);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shift;
  logic          s1;
  logic          s2;
  logic          rx_s;

`ifdef UART_RX_PARITY_EN
  logic par_bit;
`else
  assign parity_err = 1'b0;
`endif

  assign rx_s    = s2;
  assign rx_busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shift     <= '0;
      s1        <= 1'b1;
      s2        <= 1'b1;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      s1        <= rx_in;
      s2        <= s1;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            cnt   <= '0;
            idx   <= '0;
          end
        end
        START: begin
          if (cnt == HALF_END) begin
            cnt <= '0;
            if (!rx_s) begin
              state <= DATA;
              idx   <= '0;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == BIT_END) begin
            cnt   <= '0;
            shift <= {rx_s, shift[7:1]};
            idx   <= idx + 3'd1;
            if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt == BIT_END) begin
            cnt     <= '0;
            par_bit <= rx_s;
            state   <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif
        STOP: begin
          if (cnt == BIT_END) begin
            cnt <= '0;
`ifdef UART_RX_PARITY_EN
            parity_err <= par_bit ^ (^shift);
`endif
            // Straight back to IDLE so a back-to-back start bit is caught
            if (rx_s) begin
              rx_data  <= shift;
              rx_valid <= 1'b1;
              state    <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= WAIT_IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_IDLE: begin
          if (rx_s) begin
            state <= IDLE;
            cnt   <= '0;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Randomised self-checking bench for uart_rx at 16 clocks per bit.
// An expectation queue holds one entry per frame sent on the line.
module tb_uart_rx;

  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif
  localparam int LAT   = 2 + 1 + (CPB/2 - 1) + (9 + EXTRA)*CPB + 1;
  localparam int FRAME = (10 + EXTRA) * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_in = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_busy;
  logic       frame_err;
  logic       parity_err;

  uart_rx #(
    .CLK_FREQ (160),
    .BAUD_RATE(10)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_in     (rx_in),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_busy   (rx_busy),
    .frame_err (frame_err),
    .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] d;
    bit         ferr;
    bit         perr;
    int         t;
  } exp_t;

  exp_t       q[$];
  int         valid_t[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] model_data = 8'h00;
  bit         chk_en = 1'b0;
  exp_t       pe;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d",
               name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      if (rx_valid || frame_err) begin
        check("valid_ferr_excl", 32'(rx_valid & frame_err), 0);
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: valid=%0b ferr=%0b cycle %0d",
                   rx_valid, frame_err, cyc);
        end else begin
          pe = q.pop_front();
          check("pulse_kind", 32'(frame_err), 32'(pe.ferr));
          check("parity_err", 32'(parity_err), 32'(pe.perr));
          checks++;
          if (cyc < pe.t - 1 || cyc > pe.t + 1) begin
            errors++;
            $display("FAIL latency: got cycle %0d expected %0d",
                     cyc, pe.t);
          end
          if (rx_valid) begin
            model_data = pe.d;
            valid_t.push_back(cyc);
          end
        end
      end else begin
        check("parity_alone", 32'(parity_err), 0);
      end
      check("rx_data", 32'(rx_data), 32'(model_data));
    end
  end

  task automatic idle(input int n);
    rx_in = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d, input bit stop,
                      input bit pbad);
    exp_t e;
    e.d    = d;
    e.ferr = !stop;
`ifdef UART_RX_PARITY_EN
    e.perr = pbad;
`else
    e.perr = 1'b0;
`endif
    e.t = cyc + LAT;
    q.push_back(e);
    rx_in = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_in = d[i];
      repeat (CPB) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    rx_in = (^d) ^ pbad;
    repeat (CPB) @(negedge clk);
`endif
    rx_in = stop;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check(name, q.size(), 0);
    q.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    bit         stop;
    bit         pbad;
    rst   = 1'b0;
    rx_in = 1'b1;
    @(negedge clk);
    check("rst_data", 32'(rx_data), 0);
    check("rst_valid", 32'(rx_valid), 0);
    check("rst_busy", 32'(rx_busy), 0);
    check("rst_ferr", 32'(frame_err), 0);
    check("rst_perr", 32'(parity_err), 0);
    @(negedge clk);
    rst    = 1'b1;
    chk_en = 1'b1;
    idle(20);

    send(8'h55, 1'b1, 1'b0);
    idle(20);
    drain("drain_55");
    check("data_55", 32'(rx_data), 32'h55);
    check("busy_after_55", 32'(rx_busy), 0);
    check("count_55", valid_t.size(), 1);

    valid_t.delete();
    send(8'hA3, 1'b1, 1'b0);
    send(8'h0F, 1'b1, 1'b0);
    idle(20);
    drain("drain_b2b");
    check("count_b2b", valid_t.size(), 2);
    if (valid_t.size() == 2)
      check("spacing_b2b", valid_t[1] - valid_t[0], FRAME);
    check("data_0f", 32'(rx_data), 32'h0F);

    rx_in = 1'b0;
    repeat (5) @(negedge clk);
    check("glitch_busy", 32'(rx_busy), 1);
    idle(40);
    check("glitch_idle", 32'(rx_busy), 0);
    check("glitch_data", 32'(rx_data), 32'h0F);

    send(8'hFF, 1'b0, 1'b0);
    repeat (40) @(negedge clk);
    check("break_busy", 32'(rx_busy), 1);
    check("break_data", 32'(rx_data), 32'h0F);
    check("break_ferr_seen", q.size(), 0);
    idle(40);
    check("break_idle", 32'(rx_busy), 0);
    send(8'h3C, 1'b1, 1'b0);
    idle(20);
    drain("drain_3c");
    check("data_3c", 32'(rx_data), 32'h3C);

    d     = 8'h81;
    rx_in = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx_in = d[i];
      repeat (CPB) @(negedge clk);
    end
    rx_in = d[4];
    repeat (CPB/2) @(negedge clk);
    chk_en = 1'b0;
    rst    = 1'b0;
    @(negedge clk);
    check("mid_rst_data", 32'(rx_data), 0);
    check("mid_rst_valid", 32'(rx_valid), 0);
    check("mid_rst_busy", 32'(rx_busy), 0);
    check("mid_rst_ferr", 32'(frame_err), 0);
    check("mid_rst_perr", 32'(parity_err), 0);
    model_data = 8'h00;
    q.delete();
    @(negedge clk);
    rst = 1'b1;
    idle(40);
    chk_en = 1'b1;
    send(8'h81, 1'b1, 1'b0);
    idle(20);
    drain("drain_81");
    check("data_81", 32'(rx_data), 32'h81);

`ifdef UART_RX_PARITY_EN
    send(8'h07, 1'b1, 1'b1);
    idle(20);
    drain("drain_par07");
    check("data_par07", 32'(rx_data), 32'h07);
    send(8'h07, 1'b1, 1'b0);
    idle(20);
    drain("drain_good07");
`endif

    for (int k = 0; k < 16; k++) begin
      d    = 8'($urandom);
      stop = ($urandom_range(0, 5) != 0);
      pbad = 1'($urandom_range(0, 1));
      send(d, stop, pbad);
      if (!stop) begin
        repeat ($urandom_range(0, 30)) @(negedge clk);
        idle($urandom_range(20, 40));
      end else if ($urandom_range(0, 1) == 1) begin
        idle($urandom_range(1, 40));
      end
    end
    idle(20);
    drain("drain_random");
    check("busy_end", 32'(rx_busy), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
